// File: rtl/ieee_pkg.sv
// Shared IEEE-754 single-precision constants and op encodings for the FP adder
// scheduling slice.
package ieee_pkg;

    localparam int unsigned FP_WIDTH  = 32;
    localparam int unsigned FP_SIGN   = 31;
    localparam int unsigned FP_EXP_HI = 30;
    localparam int unsigned FP_EXP_LO = 23;
    localparam int unsigned FP_MAN_HI = 22;
    localparam int unsigned FP_MAN_LO = 0;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fp_op_e;

endpackage

// File: rtl/ieee_rsp_fifo.sv
// Show-ahead response FIFO; the head data reads as zero while the FIFO is empty,
// so stale RAM contents never reach the outputs.
module ieee_rsp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A write into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ieee_adder_sched.sv
// Round-robin scheduler sharing one pipelined ieee_adder among NUM_REQ clients,
// with a latency-matched tag pipeline and a credit-protected response FIFO.
module ieee_adder_sched
    import ieee_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDER_LATENCY = 3,
    parameter int unsigned RSP_DEPTH     = 4
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [FP_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [FP_WIDTH*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]          req_sub,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [FP_WIDTH-1:0]         rsp_result,
    output logic [FP_WIDTH-1:0]         adder_a,
    output logic [FP_WIDTH-1:0]         adder_b,
    output logic                        adder_add_sub,
    input  logic [FP_WIDTH-1:0]         adder_c
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);

    logic [ID_W-1:0]          rr_ptr;
    logic [ID_W-1:0]          grant_idx;
    logic [ID_W-1:0]          cand;
    logic                     grant_found;
    logic                     accept;
    logic                     pop;
    logic [CW-1:0]            credits;
    fp_op_e                   issue_op;
    logic [ADDER_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]          tag_id [ADDER_LATENCY];

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Gating with reset keeps req_ready low for the whole reset pulse, not just after an edge.
    assign accept = grant_found && (credits != '0) && !reset_in;
    assign pop    = rsp_valid && rsp_ready;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            rr_ptr   <= '0;
            adder_a  <= '0;
            adder_b  <= '0;
            issue_op <= OP_ADD;
        end else if (accept) begin
            rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            adder_a  <= req_a[grant_idx*FP_WIDTH +: FP_WIDTH];
            adder_b  <= req_b[grant_idx*FP_WIDTH +: FP_WIDTH];
            issue_op <= fp_op_e'(req_sub[grant_idx]);
        end
    end

    assign adder_add_sub = issue_op;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            tag_valid <= '0;
            for (int unsigned s = 0; s < ADDER_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= accept;
            tag_id[0]    <= grant_idx;
            for (int unsigned s = 1; s < ADDER_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    // Credits count free FIFO slots not yet promised to an in-flight operation.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            credits <= CW'(RSP_DEPTH);
        end else begin
            unique case ({accept, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    ieee_rsp_fifo #(
        .WIDTH (ID_W + FP_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clock_in),
        .rst        (reset_in),
        .push       (tag_valid[ADDER_LATENCY-1]),
        .push_data  ({tag_id[ADDER_LATENCY-1], adder_c}),
        .pop        (rsp_ready),
        .head_valid (rsp_valid),
        .head_data  ({rsp_id, rsp_result})
    );

endmodule

// File: tb/tb_ieee_adder_sched.sv
// Scoreboard bench for ieee_adder_sched with a table-driven 3-cycle adder stand-in.
module tb_ieee_adder_sched;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 3;
    localparam int unsigned DEPTH   = 4;

    logic                  clock_in = 1'b0;
    logic                  reset_in;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [31:0]           rsp_result;
    logic [31:0]           adder_a;
    logic [31:0]           adder_b;
    logic                  adder_add_sub;
    logic [31:0]           adder_c;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned n_rsp  = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    logic [31:0] pipe1;
    logic [31:0] pipe2;

    always #5 clock_in = ~clock_in;

    ieee_adder_sched #(
        .NUM_REQ       (NUM_REQ),
        .ADDER_LATENCY (LAT),
        .RSP_DEPTH     (DEPTH)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .adder_add_sub (adder_add_sub),
        .adder_c       (adder_c)
    );

    // Hand-computed IEEE-754 sums for the directed vectors used below.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [64:0] key;
        key = {sub, a, b};
        case (key)
            {1'b0, 32'h40800000, 32'h3F000000}: return 32'h40900000;
            {1'b0, 32'h3FC00000, 32'h3FC00000}: return 32'h40400000;
            {1'b1, 32'h41000000, 32'h40E00000}: return 32'h3F800000;
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {1'b0, 32'h40800000, 32'h40800000}: return 32'h41000000;
            {1'b0, 32'h3F000000, 32'h3F000000}: return 32'h3F800000;
            {1'b1, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    // Operands load at edge t; result is on adder_c before edge t+3.
    always @(posedge clock_in) begin
        pipe1 <= fake_add(adder_a, adder_b, adder_add_sub);
        pipe2 <= pipe1;
    end
    assign adder_c = pipe2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock_in) begin
        if (!reset_in && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d result %h expected no response at %0t",
                         rsp_id, rsp_result, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e[33:32]));
                check("rsp_result", rsp_result, mon_e[31:0]);
            end
        end
    end

    task automatic issue(input int unsigned idx, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input int unsigned max_wait, input bit keep, output bit ok);
        ok = 1'b0;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_sub[idx]        = sub;
        req_valid[idx]      = 1'b1;
        for (int unsigned c = 0; c < max_wait && !ok; c++) begin
            @(negedge clock_in);
            if (req_ready[idx]) begin
                ok = 1'b1;
                exp_q.push_back({2'(idx), fake_add(a, b, sub)});
            end
            @(posedge clock_in);
            #1;
        end
        if (!keep) req_valid[idx] = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned c;
        c = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && c < 60) begin
            @(posedge clock_in);
            #1;
            c++;
        end
        @(posedge clock_in);
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_empty"}, 32'(rsp_valid), 0);
    endtask

    task automatic set_all(input logic [31:0] a, input logic [31:0] b);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = a;
            req_b[i*32 +: 32] = b;
            req_sub[i]        = 1'b0;
        end
    endtask

    logic [31:0] bp_a [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40800000};
    logic [31:0] bp_b [4] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000};
    int unsigned rr_exp [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0]  grant_log [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int unsigned n_acc;
        int unsigned lat;
        int unsigned n_before;

        reset_in  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        #2 reset_in = 1'b1;
        #1;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_adder_ab", adder_a | adder_b, 0);
        check("reset_add_sub", 32'(adder_add_sub), 0);
        #20 reset_in = 1'b0;
        @(posedge clock_in);
        #1;

        // Round-robin with all four requesters continuously valid.
        rsp_ready = 1'b1;
        set_all(32'h3FC00000, 32'h3FC00000);
        req_valid = '1;
        n_acc = 0;
        for (int unsigned c = 0; c < 20 && n_acc < 6; c++) begin
            @(negedge clock_in);
            if (req_ready != '0) begin
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                grant_log[n_acc] = req_ready;
                exp_q.push_back({2'(rr_exp[n_acc]), 32'h40400000});
                n_acc++;
            end
            @(posedge clock_in);
            #1;
        end
        req_valid = '0;
        check("rr_accepts", n_acc, 6);
        for (int unsigned i = 0; i < 6; i++) begin
            check("rr_grant", 32'(grant_log[i]), 32'd1 << rr_exp[i]);
        end
        drain("rr");

        // Single request latency.
        issue(0, 32'h40800000, 32'h3F000000, 1'b0, 8, 1'b0, ok);
        check("single_accept", 32'(ok), 1);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clock_in);
            #1;
            lat++;
        end
        check("single_latency", lat, LAT);
        drain("single");

        // Subtract from requester 2.
        issue(2, 32'h41000000, 32'h40E00000, 1'b1, 8, 1'b0, ok);
        check("sub_accept", 32'(ok), 1);
        drain("sub");

        // Backpressure: four credits, then one more per pop.
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            issue(1, bp_a[i], bp_b[i], 1'b0, 4, 1'b1, ok);
            if (ok) n_acc++;
        end
        check("bp_accepts", n_acc, 4);
        issue(1, 32'h3F000000, 32'h3F000000, 1'b0, 6, 1'b1, ok);
        check("bp_stall", 32'(ok), 0);
        check("bp_ready_zero", 32'(req_ready), 0);
        rsp_ready = 1'b1;
        @(posedge clock_in);
        #1;
        rsp_ready = 1'b0;
        issue(1, 32'h3F000000, 32'h3F000000, 1'b0, 3, 1'b1, ok);
        check("bp_one_more", 32'(ok), 1);
        issue(1, 32'h40000000, 32'h3F800000, 1'b1, 8, 1'b1, ok);
        check("bp_stall_again", 32'(ok), 0);
        req_valid[1] = 1'b0;
        check("bp_full_head", 32'(rsp_valid), 1);
        drain("bp");

        // Accept and pop on the same edge leave the credit count unchanged.
        rsp_ready = 1'b0;
        issue(3, 32'h3F800000, 32'h3F800000, 1'b0, 4, 1'b0, ok);
        issue(3, 32'h40000000, 32'h40000000, 1'b0, 4, 1'b0, ok);
        repeat (5) @(posedge clock_in);
        #1;
        rsp_ready = 1'b1;
        issue(3, 32'h3F800000, 32'h40000000, 1'b0, 1, 1'b0, ok);
        rsp_ready = 1'b0;
        check("simul_accept", 32'(ok), 1);
        n_acc = 0;
        issue(3, 32'h40800000, 32'h40800000, 1'b0, 3, 1'b1, ok);
        if (ok) n_acc++;
        issue(3, 32'h3F000000, 32'h3F000000, 1'b0, 3, 1'b1, ok);
        if (ok) n_acc++;
        issue(3, 32'h40000000, 32'h3F800000, 1'b1, 6, 1'b1, ok);
        if (ok) n_acc++;
        req_valid[3] = 1'b0;
        check("simul_credits_left", n_acc, 2);
        drain("simul");

        // Asynchronous reset with three operations in flight.
        rsp_ready = 1'b0;
        issue(0, 32'h40800000, 32'h3F000000, 1'b0, 4, 1'b0, ok);
        issue(1, 32'h3FC00000, 32'h3FC00000, 1'b0, 4, 1'b0, ok);
        issue(2, 32'h41000000, 32'h40E00000, 1'b1, 4, 1'b0, ok);
        check("pre_rst_adder_a", adder_a, 32'h41000000);
        #2;
        reset_in  = 1'b1;
        req_valid = '1;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_adder_a", adder_a, 0);
        check("rst_adder_b", adder_b, 0);
        check("rst_add_sub", 32'(adder_add_sub), 0);
        exp_q.delete();
        req_valid = '0;
        @(posedge clock_in);
        @(posedge clock_in);
        #3 reset_in = 1'b0;
        rsp_ready = 1'b1;
        n_before = n_rsp;
        repeat (8) @(posedge clock_in);
        #1;
        check("rst_no_stale", n_rsp - n_before, 0);
        check("rst_idle", 32'(rsp_valid), 0);
        set_all(32'h3FC00000, 32'h3FC00000);
        req_valid = '1;
        @(negedge clock_in);
        check("rst_first_grant", 32'(req_ready), 1);
        exp_q.push_back({2'd0, 32'h40400000});
        @(posedge clock_in);
        #1;
        req_valid = '0;
        drain("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
